// File: rtl/alu_dmem_subsystem.sv
// Data-side execution block: combinational 8-bit ALU feeding a direct-mapped,
// write-back data cache (8 lines x 4 bytes) backed by a 64 x 32-bit memory.
module alu_dmem_subsystem #(
    parameter int unsigned MEM_LATENCY = 5
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [2:0] ALUOP,
    input  logic [7:0] DATA1,
    input  logic [7:0] DATA2,
    output logic [7:0] RESULT,
    output logic       ZERO,
    input  logic       READ,
    input  logic       WRITE,
    output logic [7:0] READDATA,
    output logic       BUSYWAIT
);

    localparam int unsigned CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WRITE_BACK, MEM_READ, UPDATE} state_t;

    state_t      state, next_state;
    logic [7:0]  sr_mag;
    logic [15:0] rot;

    logic [2:0]  tag_f, index_f;
    logic [1:0]  offset_f;
    logic [7:0]  valid, dirty;
    logic [2:0]  tags  [8];
    logic [31:0] lines [8];
    logic [31:0] line_data;
    logic        hit, busy, do_write, write_done;

    logic        mem_read, mem_write, mem_busy;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata, mem_readdata;
    logic [31:0] mem [64];
    logic [CW-1:0] cnt;
    logic        done, done_wr, done_match, mem_req;

    // ALU: result selected by ALUOP, purely combinational
    always_comb begin
        RESULT = '0;
        sr_mag = ~DATA2 + 8'd1;
        rot    = {DATA1, DATA1} >> DATA2[2:0];
        case (ALUOP)
            3'b000: RESULT = DATA2;
            3'b001: RESULT = DATA1 + DATA2;
            3'b010: RESULT = DATA1 & DATA2;
            3'b011: RESULT = DATA1 | DATA2;
            3'b100: RESULT = DATA1 * DATA2;
            3'b101: RESULT = (DATA2 > 8'd7) ? '0 : DATA1 << DATA2[2:0];
            3'b110: begin
                if (!DATA2[7])
                    RESULT = (DATA2 > 8'd7) ? '0 : DATA1 >> DATA2[2:0];
                else if (sr_mag > 8'd7)
                    RESULT = {8{DATA1[7]}};
                else
                    RESULT = $unsigned($signed(DATA1) >>> sr_mag[2:0]);
            end
            default: RESULT = rot[7:0];
        endcase
    end

    assign ZERO = (RESULT == 8'h00);

    assign tag_f     = RESULT[7:5];
    assign index_f   = RESULT[4:2];
    assign offset_f  = RESULT[1:0];
    assign line_data = lines[index_f];
    assign hit       = valid[index_f] && (tags[index_f] == tag_f);

    // Cache FSM next-state and memory handshake outputs
    always_comb begin
        next_state    = state;
        busy          = 1'b0;
        do_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = {tag_f, index_f};
        mem_writedata = line_data;
        case (state)
            IDLE: begin
                if (READ || WRITE) begin
                    if (hit) begin
                        // write_done releases the CPU the cycle after the byte write
                        if (WRITE && !write_done) begin
                            busy     = 1'b1;
                            do_write = 1'b1;
                        end
                    end else begin
                        busy       = 1'b1;
                        next_state = (valid[index_f] && dirty[index_f]) ? WRITE_BACK : MEM_READ;
                    end
                end
            end
            WRITE_BACK: begin
                busy        = 1'b1;
                mem_write   = 1'b1;
                mem_address = {tags[index_f], index_f};
                if (!mem_busy) next_state = MEM_READ;
            end
            MEM_READ: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                if (!mem_busy) next_state = UPDATE;
            end
            default: begin
                busy       = 1'b1;
                next_state = IDLE;
            end
        endcase
    end

    assign BUSYWAIT = busy & ~RESET;
    assign READDATA = (!RESET && state == IDLE && READ && !WRITE && hit)
                      ? line_data[{offset_f, 3'b000} +: 8] : 8'h00;

    // FSM state and per-line status bits
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            valid      <= '0;
            dirty      <= '0;
            write_done <= 1'b0;
        end else begin
            state      <= next_state;
            write_done <= do_write;
            if (do_write) dirty[index_f] <= 1'b1;
            if (state == UPDATE) begin
                valid[index_f] <= 1'b1;
                dirty[index_f] <= 1'b0;
            end
        end
    end

    // Line data and tag storage (contents are meaningless until valid is set)
    always_ff @(posedge CLK) begin
        if (do_write) lines[index_f][{offset_f, 3'b000} +: 8] <= DATA1;
        if (state == UPDATE) begin
            lines[index_f] <= mem_readdata;
            tags[index_f]  <= tag_f;
        end
    end

    assign mem_req = mem_read | mem_write;
    // A completed transfer stays "done" only while the same kind of request is held,
    // so a fill issued straight after a write-back starts a fresh transfer.
    assign done_match = done & (done_wr == mem_write);
    assign mem_busy   = mem_req & ~done_match;

    // Backing memory: fixed-latency transfer counter and word storage
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int unsigned i = 0; i < 64; i++) mem[i] <= '0;
            cnt          <= '0;
            done         <= 1'b0;
            done_wr      <= 1'b0;
            mem_readdata <= '0;
        end else if (mem_busy) begin
            if (cnt == LAST) begin
                if (mem_write) mem[mem_address] <= mem_writedata;
                else           mem_readdata     <= mem[mem_address];
                done    <= 1'b1;
                done_wr <= mem_write;
                cnt     <= '0;
            end else begin
                cnt  <= cnt + 1'b1;
                done <= 1'b0;
            end
        end else if (!mem_req) begin
            done <= 1'b0;
            cnt  <= '0;
        end
    end

endmodule

// File: tb/tb_alu_dmem_subsystem.sv
// Self-checking bench: directed ALU and cache scenarios plus randomized traffic,
// compared against a flat byte-memory / tag-table reference model.
module tb_alu_dmem_subsystem;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [2:0] ALUOP;
    logic [7:0] DATA1, DATA2;
    logic [7:0] RESULT;
    logic       ZERO;
    logic       READ, WRITE;
    logic [7:0] READDATA;
    logic       BUSYWAIT;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural byte memory plus per-index tag state
    logic [7:0] m_mem [256];
    logic       m_valid [8];
    logic       m_dirty [8];
    int         m_tag [8];

    alu_dmem_subsystem #(.MEM_LATENCY(5)) dut (
        .CLK(CLK), .RESET(RESET), .ALUOP(ALUOP), .DATA1(DATA1), .DATA2(DATA2),
        .RESULT(RESULT), .ZERO(ZERO), .READ(READ), .WRITE(WRITE),
        .READDATA(READDATA), .BUSYWAIT(BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int alu_ref(input int op, input int a, input int b);
        int r, m, sa;
        r = 0;
        case (op)
            0: r = b;
            1: r = (a + b) % 256;
            2: r = a & b;
            3: r = a | b;
            4: r = (a * b) % 256;
            5: r = (b >= 8) ? 0 : (a * (1 << b)) % 256;
            6: begin
                if (b < 128) r = (b >= 8) ? 0 : a / (1 << b);
                else begin
                    m  = 256 - b;
                    sa = (a >= 128) ? a - 256 : a;
                    if (m >= 8) r = (sa < 0) ? -1 : 0;
                    else if (sa >= 0) r = sa / (1 << m);
                    else r = -((-sa + (1 << m) - 1) / (1 << m));
                    r = (r + 256) % 256;
                end
            end
            default: begin
                m = b % 8;
                r = ((a >> m) | (a << (8 - m))) % 256;
            end
        endcase
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 0;
        end
    endtask

    task automatic alu_check(input string tag, input int op, input int a, input int b,
                             input int exp);
        @(negedge CLK);
        ALUOP = 3'(op); DATA1 = 8'(a); DATA2 = 8'(b);
        #1;
        check({tag, "_res"}, int'(RESULT), exp);
        check({tag, "_zero"}, int'(ZERO), int'(exp == 0));
    endtask

    // One load/store; stall length predicted from tag state, data from flat memory
    task automatic access(input string tag, input bit wr, input int addr, input int wdata);
        int idx, t, exp_stall, cycles;
        bit h;
        idx = (addr >> 2) % 8;
        t   = addr >> 5;
        h   = m_valid[idx] && (m_tag[idx] == t);
        if (h) exp_stall = wr ? 1 : 0;
        else   exp_stall = (m_valid[idx] && m_dirty[idx] ? 14 : 8) + (wr ? 1 : 0);
        @(negedge CLK);
        ALUOP = 3'b000; DATA2 = 8'(addr); DATA1 = 8'(wdata);
        READ = !wr; WRITE = wr;
        #1;
        cycles = 0;
        while (BUSYWAIT && cycles < 40) begin
            cycles++;
            @(negedge CLK);
            #1;
        end
        check({tag, "_stall"}, cycles, exp_stall);
        if (!wr) check({tag, "_data"}, int'(READDATA), int'(m_mem[addr]));
        @(posedge CLK);
        #1;
        READ = 1'b0; WRITE = 1'b0;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = t;
        if (!h) m_dirty[idx] = 1'b0;
        if (wr) begin
            m_dirty[idx] = 1'b1;
            m_mem[addr]  = 8'(wdata);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        int op, a, b, addr;
        bit wr;
        RESET = 1'b1; READ = 1'b0; WRITE = 1'b0;
        ALUOP = 3'b000; DATA1 = 8'h00; DATA2 = 8'h00;
        model_reset();
        repeat (3) @(negedge CLK);
        check("rst_busy", int'(BUSYWAIT), 0);
        check("rst_rdata", int'(READDATA), 0);
        RESET = 1'b0;
        @(negedge CLK);
        check("post_rst_busy", int'(BUSYWAIT), 0);

        alu_check("add_7f", 1, 8'h7F, 8'h01, 8'h80);
        alu_check("add_ff", 1, 8'hFF, 8'h01, 8'h00);
        alu_check("mul", 4, 8'h10, 8'h11, 8'h10);
        alu_check("sll", 5, 8'h81, 8'h01, 8'h02);
        alu_check("srl", 6, 8'h80, 8'h02, 8'h20);
        alu_check("sra", 6, 8'h80, 8'hFE, 8'hE0);
        alu_check("ror", 7, 8'h01, 8'h01, 8'h80);
        alu_check("sll_big", 5, 8'hFF, 8'h08, 8'h00);
        alu_check("sra_sat", 6, 8'h90, 8'hF8, 8'hFF);
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 7));
            a  = int'($urandom_range(0, 255));
            b  = int'($urandom_range(0, 255));
            alu_check("alu_rand", op, a, b, alu_ref(op, a, b));
        end

        access("rd05_miss", 1'b0, 8'h05, 0);
        access("rd06_hit", 1'b0, 8'h06, 0);
        access("wr05_hit", 1'b1, 8'h05, 8'hAB);
        access("rd05_hit", 1'b0, 8'h05, 0);
        access("wr25_evict", 1'b1, 8'h25, 8'h5C);
        access("rd05_refill", 1'b0, 8'h05, 0);
        access("rd1c_miss", 1'b0, 8'h1C, 0);
        access("rd1f_hit", 1'b0, 8'h1F, 0);

        // Reset pulsed while the fill for 8'h45 is in MEM_READ
        @(negedge CLK);
        ALUOP = 3'b000; DATA2 = 8'h45; READ = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("midrst_busy", int'(BUSYWAIT), 0);
        check("midrst_rdata", int'(READDATA), 0);
        @(negedge CLK);
        RESET = 1'b0; READ = 1'b0;
        model_reset();
        access("rd45_after_rst", 1'b0, 8'h45, 0);
        access("rd1f_after_rst", 1'b0, 8'h1F, 0);
        access("rd05_after_rst", 1'b0, 8'h05, 0);

        for (int i = 0; i < 70; i++) begin
            addr = int'($urandom_range(0, 7)) * 32 + int'($urandom_range(0, 1)) * 4
                   + int'($urandom_range(0, 3));
            wr   = 1'($urandom_range(0, 1));
            access(wr ? "rand_wr" : "rand_rd", wr, addr, int'($urandom_range(0, 255)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_dmem_subsystem.md
# alu_dmem_subsystem

Data-side execution block of the 8-bit single-cycle processor. It combines the 8-bit ALU with a direct-mapped, write-back data cache and its backing 256-byte data memory. The ALU result doubles as the load/store byte address, and the first register operand is the store data. The CPU stalls its PC and register-file write while BUSYWAIT is high.

## Interface
Parameters:
- MEM_LATENCY, 5: data-memory access time in CLK rising edges.

Ports:
- CLK  in  1  single system clock; all state updates on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ALUOP  in  3  ALU operation select.
- DATA1  in  8  ALU operand 1; also the store data for WRITE.
- DATA2  in  8  ALU operand 2: register, immediate, or negated immediate.
- RESULT  out  8  ALU result; also the cache byte address.
- ZERO  out  1  high when RESULT == 8'h00.
- READ  in  1  load request, level, held until BUSYWAIT is low.
- WRITE  in  1  store request, level, held until BUSYWAIT is low.
- READDATA  out  8  loaded byte.
- BUSYWAIT  out  1  stall request to the CPU.

## Operation
- The ALU is combinational. RESULT and ZERO are 8-bit and are valid in the same cycle as the inputs.
  - 000 FWD: DATA2.
  - 001 ADD: DATA1+DATA2, mod 256. SUB is performed as ADD with DATA2 already negated by the CPU.
  - 010 AND.
  - 011 OR.
  - 100 MUL: low 8 bits of the product.
  - 101 SLL: DATA1 << DATA2. If DATA2 ≥ 8 the result is 0.
  - 110 SR: if DATA2[7]=0, logical shift right by DATA2 (DATA2 ≥ 8 gives 0). If DATA2[7]=1, arithmetic shift right by the magnitude (−DATA2), saturating to a full sign fill at ≥ 8.
  - 111 ROR: rotate right by DATA2[2:0].
- Cache organisation:
  - 8 lines × 4 bytes, direct-mapped.
  - Address fields: tag = RESULT[7:5], index = RESULT[4:2], offset = RESULT[1:0].
  - Each line holds a valid bit, a dirty bit, a 3-bit tag and 32 bits of data.
  - Byte n of a line occupies data bits [8n+7:8n].
- Hit condition: valid && tag match, evaluated combinationally.
- Data memory:
  - 64 × 32-bit words, addressed by {tag,index} (6 bits).
  - Internal handshake signals: mem_read, mem_write, mem_address[5:0], mem_writedata[31:0], mem_readdata[31:0], mem_busy.
- FSM states:
  - IDLE
    - READ hit: READDATA = selected byte combinationally; BUSYWAIT = 0.
    - WRITE hit: BUSYWAIT = 1 in the current cycle. The next edge writes DATA1 into the byte and sets dirty; BUSYWAIT is then 0.
    - Miss on a clean or invalid line: go to MEM_READ. Miss on a dirty line: go to WRITE_BACK.
    - With no request, BUSYWAIT = 0.
  - WRITE_BACK: assert mem_write with the old {tag,index} and the line data. When mem_busy falls, go to MEM_READ.
  - MEM_READ: assert mem_read with the new {tag,index}. When mem_busy falls, go to UPDATE.
  - UPDATE: load the line from mem_readdata, set valid, clear dirty, store the tag, then go to IDLE. The request is then re-evaluated as a hit.
- BUSYWAIT is 1 whenever (READ|WRITE) and the request is not a completed read hit, and in every non-IDLE state.
- Memory transaction:
  - mem_busy rises combinationally with mem_read or mem_write.
  - The transfer completes on the MEM_LATENCY-th rising edge after the request is first seen. At that edge a read latches mem_readdata or a write commits the word, and mem_busy drops.
  - mem_read and mem_write are never both asserted.
- READ and WRITE asserted together is illegal. The cache treats it as a WRITE.
- Reset (asynchronous):
  - Cache: all valid and dirty bits cleared, FSM to IDLE, mem_read and mem_write to 0.
  - Memory: all words cleared to 0, mem_busy to 0, any pending transfer aborted.
  - Outputs: BUSYWAIT = 0, READDATA = 0.
  - A miss in flight is abandoned and restarts as a fresh miss after reset is released.

## Timing
- ALU and read hit: 0 cycles, combinational.
- Write hit: 1 cycle of BUSYWAIT.
- Clean read miss (request in cycle 0, MEM_LATENCY = 5):
  - Edge 1: enter MEM_READ.
  - Edge 6: data latched.
  - Edge 7: enter UPDATE.
  - Edge 8: enter IDLE.
  - BUSYWAIT is high in cycles 0–7 and low in cycle 8, with READDATA valid in cycle 8.
- Clean write miss: same sequence, plus 1 cycle for the hit write; BUSYWAIT falls after edge 9.
- Dirty miss: MEM_LATENCY+1 cycles more than a clean miss, for the write-back.
- A new request is accepted only in IDLE.

## Test plan
- ALU directed values:
  - ADD 8'h7F+8'h01 → 8'h80, ZERO=0.
  - ADD 8'hFF+8'h01 → 8'h00, ZERO=1.
  - MUL 8'h10×8'h11 → 8'h10.
  - SLL 8'h81 by 1 → 8'h02.
  - SR 8'h80 with DATA2 = 8'h02 → 8'h20.
  - SR 8'h80 with DATA2 = 8'hFE → 8'hE0.
  - ROR 8'h01 by 1 → 8'h80.
- After reset, READ at address 8'h05 → BUSYWAIT high for exactly 8 cycles, then READDATA = 8'h00. An immediate re-read of 8'h06 hits with BUSYWAIT = 0.
- WRITE 8'hAB to 8'h05 (hit) → 1 stall cycle; READ 8'h05 → 8'hAB with no stall.
- Eviction:
  - WRITE to 8'h25 (same index, new tag) → write-back of word 1 followed by a fill of word 9, 15-cycle stall.
  - Then READ 8'h05 → miss.
  - READDATA = 8'hAB confirms the dirty data reached memory.
- RESET pulsed in the middle of MEM_READ → BUSYWAIT drops immediately and all lines are invalid. A re-issued READ performs a full miss.
- READ of 8'h1C then 8'h1F → one miss, then a hit from the same line.
